// File: rtl/leaf_out_arbiter.sv
// Round-robin, burst-locked arbiter sharing one leaf-interface output port
// between NUM_REQ ap_vld/ap_ack streams, with a one-deep registered output slot.
module leaf_out_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 32,
    parameter int BURST_LEN = 4,
    parameter int SRC_BITS  = $clog2(NUM_REQ)
) (
    input  logic                           clk_user,
    input  logic                           reset_n,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_din,
    input  logic [NUM_REQ-1:0]             req_vld,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [DATA_BITS-1:0]           out_dout,
    output logic [SRC_BITS-1:0]            out_src,
    output logic                           out_vld,
    input  logic                           out_ack,
    output logic                           busy
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state_q, state_d;
    logic [SRC_BITS-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SRC_BITS-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_vld_q, out_vld_d;
    logic [DATA_BITS-1:0]   out_dout_q, out_dout_d;
    logic [SRC_BITS-1:0]    out_src_q, out_src_d;

    logic [DATA_BITS-1:0]   din_arr [NUM_REQ];
    logic [SRC_BITS-1:0]    sel;
    logic [SRC_BITS-1:0]    cand;
    logic                   found;
    logic                   slot_free;
    logic                   accept;
    logic                   burst_done;

    function automatic logic [SRC_BITS-1:0] next_idx(input logic [SRC_BITS-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + SRC_BITS'(1);
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign din_arr[i] = req_din[i*DATA_BITS +: DATA_BITS];
    end

    assign slot_free = !out_vld_q || out_ack;

    // Grant selection: rotating priority scan in IDLE, owner-only during a burst.
    // The scan runs from the far end so the candidate closest to rr_ptr wins.
    always_comb begin
        sel   = rr_ptr_q;
        cand  = rr_ptr_q;
        found = 1'b0;
        if (state_q == IDLE) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = SRC_BITS'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (req_vld[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end else begin
            sel   = owner_q;
            found = req_vld[owner_q];
        end
    end

    always_comb begin
        req_ack = '0;
        if (reset_n && slot_free && found) begin
            req_ack[sel] = 1'b1;
        end
    end

    assign accept     = |req_ack;
    assign burst_done = (cnt_q + CNT_W'(1)) == CNT_W'(BURST_LEN);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        out_vld_d  = out_vld_q;
        out_dout_d = out_dout_q;
        out_src_d  = out_src_q;

        if (accept) begin
            out_vld_d  = 1'b1;
            out_dout_d = din_arr[sel];
            out_src_d  = sel;
        end else if (out_ack) begin
            out_vld_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (BURST_LEN == 1) begin
                        rr_ptr_d = next_idx(sel);
                    end else begin
                        state_d = BURST;
                        owner_d = sel;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            BURST: begin
                if (accept) begin
                    if (burst_done) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_idx(owner_q);
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (slot_free && !req_vld[owner_q]) begin
                    // Owner ran dry: release without granting, costs one bubble.
                    state_d  = IDLE;
                    rr_ptr_d = next_idx(owner_q);
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_dout_q <= '0;
            out_src_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_dout_q <= out_dout_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_dout = out_dout_q;
    assign out_src  = out_src_q;
    assign busy     = (state_q == BURST) || out_vld_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Randomized and directed bench for leaf_out_arbiter against a queue/integer
// model of the grant rules, plus a per-stream ordering scoreboard.
module tb_leaf_out_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N*DW-1:0] req_din = '0;
    logic [N-1:0]    req_vld = '0;
    logic [N-1:0]    req_ack;
    logic [DW-1:0]   out_dout;
    logic [1:0]      out_src;
    logic            out_vld;
    logic            out_ack = 1'b0;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int seq [N];
    int dlv [N];

    int          m_owner;
    int          m_words;
    int          m_rr;
    logic        m_vld;
    logic [31:0] m_dout;
    int          m_src;

    int          glog [$];
    logic [31:0] dlog [$];
    logic        vlog [$];
    logic [31:0] olog [$];
    int          olog_cyc [$];

    leaf_out_arbiter #(
        .NUM_REQ  (N),
        .DATA_BITS(DW),
        .BURST_LEN(BL),
        .SRC_BITS (2)
    ) dut (
        .clk_user(clk),
        .reset_n (reset_n),
        .req_din (req_din),
        .req_vld (req_vld),
        .req_ack (req_ack),
        .out_dout(out_dout),
        .out_src (out_src),
        .out_vld (out_vld),
        .out_ack (out_ack),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] word(input int i, input int n);
        return (32'(i) << 24) | 32'((n + 1) * 17);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_words = 0;
        m_rr    = 0;
        m_vld   = 1'b0;
        m_dout  = '0;
        m_src   = 0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            dlv[i] = 0;
        end
    endtask

    task automatic clear_logs();
        glog.delete();
        dlog.delete();
        vlog.delete();
        olog.delete();
        olog_cyc.delete();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, holds across an edge.
    task automatic reset_check(input string tag);
        reset_n = 1'b0;
        req_vld = '1;
        #1;
        chk({tag, "_req_ack"}, req_ack, 0);
        chk({tag, "_out_vld"}, out_vld, 0);
        chk({tag, "_out_dout"}, out_dout, 0);
        chk({tag, "_out_src"}, out_src, 0);
        chk({tag, "_busy"}, busy, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req_vld = '0;
        model_reset();
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic [N-1:0] v, input logic a);
        int          cand;
        int          eg;
        int          g;
        logic        slot;
        logic [N-1:0] eack;
        req_vld = v;
        out_ack = a;
        for (int i = 0; i < N; i++) req_din[i*DW +: DW] = word(i, seq[i]);
        #2;
        slot = !m_vld || a;
        cand = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (cand < 0 && v[(m_rr + k) % N]) cand = (m_rr + k) % N;
        end else if (v[m_owner]) begin
            cand = m_owner;
        end
        eg   = slot ? cand : -1;
        eack = (eg >= 0) ? (N'(1) << eg) : '0;

        chk("req_ack", req_ack, eack);
        chk("out_vld", out_vld, m_vld);
        chk("out_dout", out_dout, m_dout);
        chk("out_src", out_src, m_src);
        chk("busy", busy, (m_owner >= 0) || m_vld);

        g = -1;
        for (int i = 0; i < N; i++) if (req_ack[i]) g = i;
        glog.push_back(g);
        dlog.push_back(out_dout);
        vlog.push_back(out_vld);
        if (out_vld && out_ack) begin
            chk("order", out_dout, word(int'(out_src), dlv[out_src]));
            dlv[out_src]++;
            olog.push_back(out_dout);
            olog_cyc.push_back(cyc);
        end

        if (eg >= 0) begin
            m_vld  = 1'b1;
            m_dout = word(eg, seq[eg]);
            m_src  = eg;
            if (m_owner < 0) begin
                if (BL == 1) m_rr = (eg + 1) % N;
                else begin
                    m_owner = eg;
                    m_words = 1;
                end
            end else begin
                m_words++;
                if (m_words == BL) begin
                    m_owner = -1;
                    m_rr    = (eg + 1) % N;
                end
            end
        end else begin
            if (a) m_vld = 1'b0;
            if (m_owner >= 0 && slot && !v[m_owner]) begin
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        if (g >= 0) seq[g]++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    int exp4 [9]  = '{1, 1, -1, 3, 3, 3, 3, -1, 0};
    int exp5 [10] = '{0, 0, -1, -1, -1, -1, -1, 0, 0, 1};

    initial begin
        model_reset();
        @(posedge clk);
        #1;

        // T1: reset with every stream requesting
        reset_check("t1");

        // T2: single stream, three words, no gaps
        clear_logs();
        repeat (3) step(4'b0100, 1'b1);
        repeat (2) step(4'b0000, 1'b1);
        chk("t2_count", olog.size(), 3);
        if (olog.size() == 3) begin
            chk("t2_w0", olog[0], 32'h0200_0011);
            chk("t2_w1", olog[1], 32'h0200_0022);
            chk("t2_w2", olog[2], 32'h0200_0033);
            chk("t2_gap1", olog_cyc[1] - olog_cyc[0], 1);
            chk("t2_gap2", olog_cyc[2] - olog_cyc[1], 1);
        end

        // T3: all streams valid, bursts of four rotating
        reset_check("t3rst");
        clear_logs();
        repeat (33) step(4'b1111, 1'b1);
        for (int k = 0; k < 32; k++) chk("t3_src", glog[k], (k / 4) % 4);
        chk("t3_words", olog.size(), 32);
        step(4'b0000, 1'b1);

        // T4: early release, bubble, next owner, pointer wraps to 0
        reset_check("t4rst");
        clear_logs();
        repeat (2) step(4'b1010, 1'b1);
        repeat (5) step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b1111, 1'b1);
        for (int k = 0; k < 9; k++) chk("t4_grant", glog[k], exp4[k]);

        // T5: backpressure mid-burst, burst still ends at BL words
        reset_check("t5rst");
        clear_logs();
        repeat (2) step(4'b0001, 1'b1);
        repeat (5) step(4'b0001, 1'b0);
        repeat (2) step(4'b0001, 1'b1);
        step(4'b0011, 1'b1);
        for (int k = 0; k < 10; k++) chk("t5_grant", glog[k], exp5[k]);
        for (int k = 2; k < 7; k++) begin
            chk("t5_hold_dout", dlog[k], 32'h0000_0022);
            chk("t5_hold_vld", vlog[k], 1);
        end

        // T6: reset in the middle of a stream-2 burst
        reset_check("t6rst");
        repeat (2) step(4'b0100, 1'b1);
        chk("t6_pre_vld", out_vld, 1);
        chk("t6_pre_busy", busy, 1);
        reset_check("t6");
        clear_logs();
        step(4'b1111, 1'b1);
        chk("t6_restart", glog[0], 0);

        // Random traffic with random backpressure
        reset_check("rnd_rst");
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] v;
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(3) != 0);
            step(v, $urandom_range(3) != 0);
        end
        repeat (10) step(4'b0000, 1'b1);
        for (int i = 0; i < N; i++) chk("no_loss", dlv[i], seq[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
